min_max_index_matrix_row_seq: RTL and testbench
===============================================

# min_max_index_matrix_row_seq

Sequential, handshaked successor to the parallel row min-index block. It accepts an N×M matrix of IEEE floating-point values and reports, per row, the index and value of the minimum or maximum element, selected per transaction. It scans one column per cycle with N row comparators in parallel, so area does not grow with M. It sits after the distance/score matrix stages and feeds argmin/argmax consumers.

## Interface
- BITS, 16, element width; must be 16/32/64 for PRECISION HALF/SINGLE/DOUBLE, otherwise elaboration `$error`
- PRECISION, "HALF", "HALF", "SINGLE" or "DOUBLE"; sets exponent width 5/8/11 for NaN detection
- INDEX_BITS, 4, index width; must satisfy M ≤ 2^INDEX_BITS, otherwise elaboration `$error`
- N, 3, rows (independent results)
- M, 2, columns per row; M ≥ 1
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  matrix and mode present
- in_ready  out  1  block can accept
- mode_max  in  1  0 = min, 1 = max; sampled at accept
- a  in  [BITS-1:0] a[N][M]  input matrix; sampled at accept
- out_valid  out  1  results valid; held until out_ready
- out_ready  in  1  consumer accepts results
- index  out  [INDEX_BITS-1:0] index[N]  column of selected element, per row
- c  out  [BITS-1:0] c[N]  selected element value, per row

## Operation
- FSM states:
  - IDLE: in_ready = 1. On `in_valid && in_ready`, latch `a` and `mode_max`, set best[r] = a[r][0], idx[r] = 0, col = 1. Go to SCAN if M > 1, else to DONE.
  - SCAN: each cycle, every row compares a[r][col] against best[r] and replaces best/idx on strict win. If col == M-1, go to DONE; else increment col.
  - DONE: out_valid = 1, with index/c driven from idx/best. On out_ready, go to IDLE.
- Comparison uses an ordered key:
  - sign = 1: key = ~x
  - sign = 0: key = x ^ (1 << (BITS-1))
  - Keys compare as unsigned BITS-bit values.
  - Min replaces on key(new) < key(best); max replaces on key(new) > key(best).
  - -0.0 orders below +0.0. -inf and +inf order correctly.
- Ties: the lowest column index wins, because replacement requires a strict win.
- Rows are fully independent. All rows finish on the same cycle.
- index/c update only on entry to DONE. After the handshake they hold the last result until the next DONE.
- in_ready is low in SCAN and DONE. in_valid in those states is ignored, with no queueing.
- NaN handling: see Configuration.

## Timing
- Accept edge at cycle T. out_valid rises at T+M and stays high until the edge where out_ready = 1.
- in_ready returns high the cycle after the out_ready handshake. Throughput is one matrix per M+1 cycles with out_ready tied high.
- If out_ready is already high when out_valid rises, the handshake completes at that edge.
- M = 1: DONE at T+1, index = 0, c = a[r][0].
- Reset values: in_ready = 1 (IDLE), out_valid = 0, index[*] = 0, c[*] = 0, col = 0.
- Reset asserted in SCAN or DONE aborts the transaction immediately. The result is lost and no out_valid pulse is produced. The block is in IDLE on the first edge after rstn deasserts.
- `a` and `mode_max` may change freely after the accept edge.

## Configuration
- Macro: MIN_MAX_INDEX_NAN_SKIP_EN.
- Defined:
  - An element is NaN when its exponent is all ones and its mantissa is nonzero.
  - A NaN candidate never replaces best.
  - A non-NaN candidate always replaces a NaN best.
  - If a row is all NaN, the result is index 0 and c = a[r][0].
- Undefined: NaNs go through the ordered key unchanged. Positive NaN orders above +inf; negative NaN orders below -inf.

## Test plan
All values are HALF, N = 3, M = 4, out_ready = 1 unless stated.
- Min: row0 = {0x4000, 0x3C00, 0x3800, 0x3C00}, row1 = {0xBC00, 0x3C00, 0x4000, 0x3800}, row2 = {0x3C00 ×4} -> index = {2, 0, 0}, c = {0x3800, 0xBC00, 0x3C00}, out_valid at T+4.
- Same matrix with mode_max = 1 -> index = {0, 2, 0}, c = {0x4000, 0x4000, 0x3C00}.
- Signed zero and infinity: row0 = {0x0000, 0x8000, 0x7C00, 0xFC00}, min -> index 3 (0xFC00); max -> index 2 (0x7C00). Min over {0x0000, 0x8000} with M = 2 -> index 1.
- NaN, row0 = {0x7E00, 0x3C00, 0x7E00, 0x4000}, min:
  - With MIN_MAX_INDEX_NAN_SKIP_EN -> index 1, c = 0x3C00.
  - Without it -> min picks index 1; max picks index 0.
  - All-NaN row with the macro -> index 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid. Required: out_valid, index and c stay stable, in_ready = 0, and a second in_valid is ignored. Release out_ready -> in_ready = 1 the next cycle and the next matrix is accepted.
- Drop rstn at T+2 mid-SCAN. Required: out_valid = 0, index/c = 0, in_ready = 1 after release, no stale result. A new matrix then completes at its own T+4.

Source files
------------

// File: rtl/min_max_index_matrix_row_seq.sv
// Per-row argmin/argmax over an N x M IEEE float matrix, scanning one column per cycle.
// Latency: accept cycle T, result valid in cycle T+M; one matrix per M+1 cycles with out_ready high.
// Backpressure: in_ready is low from accept until the result handshake; out_valid holds until out_ready.
// Optional feature macro: MIN_MAX_INDEX_NAN_SKIP_EN (NaN candidates never win; non-NaN replaces NaN best).
// Ports:
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; a[N][M] and mode_max sampled at accept
//   mode_max            0 = minimum, 1 = maximum
//   out_valid/out_ready result handshake
//   index[N], c[N]      column and value of selected element per row
module min_max_index_matrix_row_seq #(
  parameter int BITS       = 16,
  parameter     PRECISION  = "HALF",
  parameter int INDEX_BITS = 4,
  parameter int N          = 3,
  parameter int M          = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode_max,
  input  logic [BITS-1:0]       a [N][M],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INDEX_BITS-1:0] index [N],
  output logic [BITS-1:0]       c [N]
);

  // Column counter only needs to address M columns.
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_COL  = CW'(M - 1);
  // With M == 1 the scan never runs; keep the counter inside the array range.
  localparam logic [CW-1:0] FIRST_COL = CW'((M > 1) ? 1 : 0);

  generate
    if (!((PRECISION == "HALF"   && BITS == 16) ||
          (PRECISION == "SINGLE" && BITS == 32) ||
          (PRECISION == "DOUBLE" && BITS == 64))) begin : g_bad_bits
      $error("min_max_index_matrix_row_seq: BITS does not match PRECISION");
    end
    if (M < 1 || M > (1 << INDEX_BITS)) begin : g_bad_m
      $error("min_max_index_matrix_row_seq: M must be in 1..2**INDEX_BITS");
    end
  endgenerate

  // Map a float onto an unsigned key whose integer order matches float order
  // (-0.0 sorts just below +0.0, infinities at the ends).
  function automatic logic [BITS-1:0] f_key(input logic [BITS-1:0] x);
    f_key = x[BITS-1] ? ~x : (x ^ {1'b1, {(BITS-1){1'b0}}});
  endfunction

`ifdef MIN_MAX_INDEX_NAN_SKIP_EN
  localparam int EXP_W = (PRECISION == "DOUBLE") ? 11 :
                         (PRECISION == "SINGLE") ? 8 : 5;

  function automatic logic f_is_nan(input logic [BITS-1:0] x);
    f_is_nan = (&x[BITS-2 -: EXP_W]) && (|x[BITS-EXP_W-2:0]);
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BITS-1:0]       r_mat   [N][M];
  logic                  r_mode;
  logic [CW-1:0]         r_col;
  logic [BITS-1:0]       r_best  [N];
  logic [INDEX_BITS-1:0] r_idx   [N];
  logic [BITS-1:0]       r_c     [N];
  logic [INDEX_BITS-1:0] r_index [N];

  logic [BITS-1:0]       w_cand  [N];
  logic                  w_win   [N];
  logic                  w_repl  [N];
  logic [BITS-1:0]       w_nbest [N];
  logic [INDEX_BITS-1:0] w_nidx  [N];
  logic                  w_accept;
  logic                  w_last;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (M > 1) ? S_SCAN : S_DONE;
      end
      S_SCAN: begin
        if (r_col == LAST_COL) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_SCAN) && (r_col == LAST_COL);

  // ---------------- Row comparators ----------------
  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_cand[r] = r_mat[r][r_col];
      w_win[r]  = r_mode ? (f_key(w_cand[r]) > f_key(r_best[r]))
                         : (f_key(w_cand[r]) < f_key(r_best[r]));
`ifdef MIN_MAX_INDEX_NAN_SKIP_EN
      w_repl[r] = !f_is_nan(w_cand[r]) && (f_is_nan(r_best[r]) || w_win[r]);
`else
      w_repl[r] = w_win[r];
`endif
      // Strict win only: ties keep the lower column.
      w_nbest[r] = w_repl[r] ? w_cand[r] : r_best[r];
      w_nidx[r]  = w_repl[r] ? INDEX_BITS'(r_col) : r_idx[r];
    end
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode <= 1'b0;
      r_col  <= '0;
      for (int r = 0; r < N; r++) begin
        r_best[r]  <= '0;
        r_idx[r]   <= '0;
        r_c[r]     <= '0;
        r_index[r] <= '0;
        for (int k = 0; k < M; k++) r_mat[r][k] <= '0;
      end
    end else if (w_accept) begin
      r_mode <= mode_max;
      r_col  <= FIRST_COL;
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < M; k++) r_mat[r][k] <= a[r][k];
        r_best[r] <= a[r][0];
        r_idx[r]  <= '0;
        // Single-column matrices go straight to DONE, so publish here.
        if (M == 1) begin
          r_index[r] <= '0;
          r_c[r]     <= a[r][0];
        end
      end
    end else if (r_state == S_SCAN) begin
      if (r_col != LAST_COL) r_col <= r_col + 1'b1;
      for (int r = 0; r < N; r++) begin
        r_best[r] <= w_nbest[r];
        r_idx[r]  <= w_nidx[r];
        // Outputs change only on entry to DONE and then hold.
        if (w_last) begin
          r_index[r] <= w_nidx[r];
          r_c[r]     <= w_nbest[r];
        end
      end
    end
  end

  assign index = r_index;
  assign c     = r_c;

endmodule

// File: tb/tb_min_max_index_matrix_row_seq.sv
// Directed self-checking bench for min_max_index_matrix_row_seq (HALF, N=3, M=4, plus an M=1 instance).
module tb_min_max_index_matrix_row_seq;

  logic        clk;
  logic        rstn;
  logic        in_valid, in_ready, mode_max, out_valid, out_ready;
  logic [15:0] a     [3][4];
  logic [3:0]  index [3];
  logic [15:0] c     [3];

  logic        in_valid1, in_ready1, mode_max1, out_valid1, out_ready1;
  logic [15:0] a1     [3][1];
  logic [3:0]  index1 [3];
  logic [15:0] c1     [3];

  int n_checks = 0;
  int n_pass   = 0;

  min_max_index_matrix_row_seq #(
    .BITS(16), .PRECISION("HALF"), .INDEX_BITS(4), .N(3), .M(4)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .mode_max(mode_max), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .index(index), .c(c)
  );

  min_max_index_matrix_row_seq #(
    .BITS(16), .PRECISION("HALF"), .INDEX_BITS(4), .N(3), .M(1)
  ) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1),
    .mode_max(mode_max1), .a(a1), .out_valid(out_valid1), .out_ready(out_ready1),
    .index(index1), .c(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] idx_v();
    return {index[0], index[1], index[2]};
  endfunction

  function automatic logic [47:0] c_v();
    return {c[0], c[1], c[2]};
  endfunction

  task automatic set_row(input int r, input logic [63:0] v);
    for (int k = 0; k < 4; k++) a[r][k] = v[63-16*k -: 16];
  endtask

  // Called at a negedge. Presents the matrix, accepts on the next edge, then
  // corrupts the inputs and waits for out_valid. lat = cycles from accept cycle.
  task automatic run_mat(input logic mode, output int lat);
    mode_max = mode;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mode_max = ~mode;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) a[r][k] = a[r][k] ^ 16'h8000;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; mode_max = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; mode_max1 = 1'b0; out_ready1 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) a[r][k] = 16'h0;
      a1[r][0] = 16'h0;
    end
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (idx_v() !== 12'h000) $display("FAIL reset_index got %h want 000", idx_v()); else n_pass++;
    n_checks++; if (c_v() !== 48'h0) $display("FAIL reset_c got %h want 0", c_v()); else n_pass++;
    n_checks++; if ({in_ready1, out_valid1} !== 2'b10) $display("FAIL reset_m1_hs got %b want 10", {in_ready1, out_valid1}); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_min;
    int lat;
    set_row(0, 64'h4000_3C00_3800_3C00);
    set_row(1, 64'hBC00_3C00_4000_3800);
    set_row(2, 64'h3C00_3C00_3C00_3C00);
    run_mat(1'b0, lat);
    n_checks++; if (lat !== 4) $display("FAIL min_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (idx_v() !== 12'h200) $display("FAIL min_index got %h want 200", idx_v()); else n_pass++;
    n_checks++; if (c_v() !== 48'h3800_BC00_3C00) $display("FAIL min_c got %h want 3800bc003c00", c_v()); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL min_in_ready_done got %b want 0", in_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL min_after_hs got %b want 01", {out_valid, in_ready}); else n_pass++;
  endtask

  task automatic test_max;
    int lat;
    set_row(0, 64'h4000_3C00_3800_3C00);
    set_row(1, 64'hBC00_3C00_4000_3800);
    set_row(2, 64'h3C00_3C00_3C00_3C00);
    run_mat(1'b1, lat);
    n_checks++; if (lat !== 4) $display("FAIL max_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (idx_v() !== 12'h020) $display("FAIL max_index got %h want 020", idx_v()); else n_pass++;
    n_checks++; if (c_v() !== 48'h4000_4000_3C00) $display("FAIL max_c got %h want 400040003c00", c_v()); else n_pass++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_signed_zero_inf;
    int lat;
    set_row(0, 64'h0000_8000_7C00_FC00);
    set_row(1, 64'h0000_8000_0000_0000);
    set_row(2, 64'h7C00_FC00_7C00_FC00);
    run_mat(1'b0, lat);
    n_checks++; if (lat !== 4) $display("FAIL szi_min_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (idx_v() !== 12'h311) $display("FAIL szi_min_index got %h want 311", idx_v()); else n_pass++;
    n_checks++; if (c_v() !== 48'hFC00_8000_FC00) $display("FAIL szi_min_c got %h want fc008000fc00", c_v()); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_row(0, 64'h0000_8000_7C00_FC00);
    set_row(1, 64'h0000_8000_0000_0000);
    set_row(2, 64'h7C00_FC00_7C00_FC00);
    run_mat(1'b1, lat);
    n_checks++; if (idx_v() !== 12'h200) $display("FAIL szi_max_index got %h want 200", idx_v()); else n_pass++;
    n_checks++; if (c_v() !== 48'h7C00_0000_7C00) $display("FAIL szi_max_c got %h want 7c0000007c00", c_v()); else n_pass++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_nan;
    int lat;
    logic [11:0] e_idx_min, e_idx_max;
    logic [47:0] e_c_min, e_c_max;
`ifdef MIN_MAX_INDEX_NAN_SKIP_EN
    e_idx_min = 12'h102; e_c_min = 48'h3C00_7E00_BC00;
    e_idx_max = 12'h301; e_c_max = 48'h4000_7E00_3C00;
`else
    e_idx_min = 12'h120; e_c_min = 48'h3C00_FE00_FE00;
    e_idx_max = 12'h003; e_c_max = 48'h7E00_7E00_7E00;
`endif
    set_row(0, 64'h7E00_3C00_7E00_4000);
    set_row(1, 64'h7E00_7C01_FE00_7E00);
    set_row(2, 64'hFE00_3C00_BC00_7E00);
    run_mat(1'b0, lat);
    n_checks++; if (lat !== 4) $display("FAIL nan_min_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (idx_v() !== e_idx_min) $display("FAIL nan_min_index got %h want %h", idx_v(), e_idx_min); else n_pass++;
    n_checks++; if (c_v() !== e_c_min) $display("FAIL nan_min_c got %h want %h", c_v(), e_c_min); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_row(0, 64'h7E00_3C00_7E00_4000);
    set_row(1, 64'h7E00_7C01_FE00_7E00);
    set_row(2, 64'hFE00_3C00_BC00_7E00);
    run_mat(1'b1, lat);
    n_checks++; if (idx_v() !== e_idx_max) $display("FAIL nan_max_index got %h want %h", idx_v(), e_idx_max); else n_pass++;
    n_checks++; if (c_v() !== e_c_max) $display("FAIL nan_max_c got %h want %h", c_v(), e_c_max); else n_pass++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    set_row(0, 64'h4000_3C00_3800_3C00);
    set_row(1, 64'hBC00_3C00_4000_3800);
    set_row(2, 64'h3C00_3C00_3C00_3C00);
    run_mat(1'b0, lat);
    n_checks++; if (lat !== 4) $display("FAIL bp_latency got %0d want 4", lat); else n_pass++;
    // Offer a second matrix while the result is stalled; it must not be taken.
    set_row(0, 64'h0000_8000_7C00_FC00);
    set_row(1, 64'h0000_8000_0000_0000);
    set_row(2, 64'h7C00_FC00_7C00_FC00);
    mode_max = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, idx_v(), c_v()} !== {1'b1, 1'b0, 12'h200, 48'h3800_BC00_3C00})
        $display("FAIL bp_hold_cycle%0d got v=%b r=%b idx=%h c=%h want v=1 r=0 idx=200 c=3800bc003c00",
                 i, out_valid, in_ready, idx_v(), c_v());
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got %b want 01", {out_valid, in_ready}); else n_pass++;
    run_mat(1'b0, lat);
    n_checks++; if (lat !== 4) $display("FAIL bp_next_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (idx_v() !== 12'h311) $display("FAIL bp_next_index got %h want 311", idx_v()); else n_pass++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat;
    int seen;
    set_row(0, 64'h4000_3C00_3800_3C00);
    set_row(1, 64'hBC00_3C00_4000_3800);
    set_row(2, 64'h3C00_3C00_3C00_3C00);
    mode_max = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL abort_hs got %b want 01", {out_valid, in_ready}); else n_pass++;
    n_checks++; if ({idx_v(), c_v()} !== 60'h0) $display("FAIL abort_clear got idx=%h c=%h want 0", idx_v(), c_v()); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL abort_no_stale got %0d pulses want 0", seen); else n_pass++;
    n_checks++; if ({in_ready, idx_v(), c_v()} !== {1'b1, 60'h0}) $display("FAIL abort_idle got r=%b idx=%h c=%h want r=1 0 0", in_ready, idx_v(), c_v()); else n_pass++;
    set_row(0, 64'h4000_3C00_3800_3C00);
    set_row(1, 64'hBC00_3C00_4000_3800);
    set_row(2, 64'h3C00_3C00_3C00_3C00);
    run_mat(1'b0, lat);
    n_checks++; if (lat !== 4) $display("FAIL abort_next_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (idx_v() !== 12'h200) $display("FAIL abort_next_index got %h want 200", idx_v()); else n_pass++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_m1;
    a1[0][0] = 16'h4000; a1[1][0] = 16'hBC00; a1[2][0] = 16'h7C00;
    mode_max1 = 1'b0;
    in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    a1[0][0] = 16'h0; a1[1][0] = 16'h0; a1[2][0] = 16'h0;
    n_checks++; if ({out_valid1, in_ready1} !== 2'b10) $display("FAIL m1_done got %b want 10", {out_valid1, in_ready1}); else n_pass++;
    n_checks++; if ({index1[0], index1[1], index1[2]} !== 12'h000) $display("FAIL m1_index got %h want 000", {index1[0], index1[1], index1[2]}); else n_pass++;
    n_checks++; if ({c1[0], c1[1], c1[2]} !== 48'h4000_BC00_7C00) $display("FAIL m1_c got %h want 4000bc007c00", {c1[0], c1[1], c1[2]}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({out_valid1, in_ready1} !== 2'b01) $display("FAIL m1_after_hs got %b want 01", {out_valid1, in_ready1}); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_min;
    test_max;
    test_signed_zero_inf;
    test_nan;
    test_backpressure;
    test_reset_abort;
    test_m1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
